fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core, sitting directly upstream of the instruction memory and feeding the decode stage. It owns the program counter, issues one word-aligned fetch request at a time to the instruction memory and waits on its `done` response. Returned words are buffered in a 2-entry queue tagged with their PC, and the block accepts branch/jump redirects from later stages.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk`  input  1  system clock, all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `imem_adr`  output  32  fetch byte address to instruction memory, always word-aligned.
- `imem_req`  output  1  fetch request; `imem_adr` is held stable while high.
- `imem_rdata`  input  32  instruction word from memory; valid when `imem_done`=1.
- `imem_done`  input  1  response strobe; sampled only while `imem_req`=1.
- `redirect`  input  1  one-cycle pulse: discard all fetched/in-flight words and restart at `redirect_pc`.
- `redirect_pc`  input  32  new PC; bits [1:0] are ignored and forced to 0.
- `id_ready`  input  1  decode stage accepts the head word this cycle.
- `id_valid`  output  1  head-of-queue word is valid.
- `id_instr`  output  32  head-of-queue instruction.
- `id_pc`  output  32  PC of `id_instr`.

## Operation
- The FSM has three states.
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data will be kept.
  - DRAIN: request outstanding, data will be discarded after a redirect.
- Queue: 2 entries of {pc, instr}; `count` is 0..2.
- Issue rule: in IDLE, when `count` + 0 < 2 after this cycle's pop, go to WAIT. On that transition, `imem_req`<=1 and `imem_adr`<=`pc`.
  - At most one request is ever outstanding.
  - When a response arrives, `count` after push must not exceed 2.
- WAIT, `imem_done`=1: push {`imem_adr`, `imem_rdata`} and set `pc`<=`imem_adr`+4.
  - If there is space for another word, stay in WAIT with the new address. This allows back-to-back issue.
  - Otherwise go to IDLE with `imem_req`<=0.
- Pop: when `id_valid`&&`id_ready`. Pop and push may occur in the same cycle; `count` is then unchanged.
- Redirect has priority over push and pop in the same cycle.
  - The queue is flushed (`count`<=0) and `pc`<=`redirect_pc`&~3.
  - From IDLE: go to WAIT next edge with `imem_adr`=new pc.
  - From WAIT with `imem_done`=0: go to DRAIN, keeping `imem_req` and the old `imem_adr` stable until done.
  - From WAIT with `imem_done`=1 in the same cycle: that word is dropped, and the block goes to WAIT at the new pc.
  - DRAIN with `imem_done`=1: the word is dropped, `imem_adr`<=pc, and the block goes to WAIT.
  - A second redirect while in DRAIN only updates `pc`.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- `id_instr`/`id_pc` show the head entry when `id_valid`=1. They hold their last value when the queue is empty.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - state IDLE, `imem_req`=0, `imem_adr`=`RESET_PC`, `pc`=`RESET_PC`;
  - `count`=0, `id_valid`=0, `id_instr`=0, `id_pc`=0.
- First rising edge after `rst_n` rises: `imem_req`=1, `imem_adr`=`RESET_PC`.
- Fetch latency: a word sampled with `imem_done` at edge N makes `id_valid`=1 after edge N, in the cycle following N.
- Throughput: with `imem_done` tied to 1 and `id_ready`=1, one word is delivered per cycle, and the address advances by 4 every cycle.
- Backpressure: with `id_ready`=0, exactly 2 words are fetched, then `imem_req` drops. It reasserts on the edge after the first pop.
- Redirect latency: a redirect at edge N with no outstanding request puts `imem_adr`=target after edge N, and `id_valid`=0 after edge N.
- `id_valid` never shows a word fetched before a redirect once the redirect edge has passed.
- Reset mid-request drops `imem_req` immediately, asynchronously.

## Test plan
- Reset/start: hold `rst_n`=0 for 3 cycles, release, `imem_done`=1, `id_ready`=1, memory returns addr^32'hA5A5_0000. Expect `id_pc` sequence 0, 4, 8, 12 on consecutive cycles with matching `id_instr`.
- Slow memory: `imem_done` asserted 3 cycles after each request. Expect `imem_adr` stable for those 3 cycles and one word per 3 cycles, in order, with no duplicates.
- Backpressure: `id_ready`=0 from reset. Expect exactly 2 responses accepted (pc 0, 4), `imem_req`=0, and `id_pc`=0 held. Raise `id_ready` for one cycle: expect head 4, then a new request at 8.
- Redirect during WAIT: request to 0x10 pending, pulse `redirect` with `redirect_pc`=0x103 and return done 2 cycles later. Expect the 0x10 word never valid, the next request at 0x100, and the first `id_pc`=0x100.
- Redirect colliding with done and pop: queue holding 2 entries, `redirect`, `imem_done` and `id_ready` all in one cycle. Expect `count`=0, `id_valid`=0 next cycle, and the next request at the target.
- Wrap-around: `redirect_pc`=32'hFFFF_FFF8. Expect `id_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to instruction
// memory, buffers returned words with their PC in a 2-entry queue, handles redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_adr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_done,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [1:0]  dbg_state
);

   // Handshakes: a request is live while imem_req=1 and completes on a cycle with
   // imem_done=1; a queue word transfers on a cycle with id_valid=1 and id_ready=1.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   localparam logic [31:0] RESET_ADR = {RESET_PC[31:2], 2'b00};

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] adr_q, adr_d;
   logic        req_q, req_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
   logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;

   logic        pop;
   logic        push;
   logic [1:0]  count_pop;
   logic [31:0] target_pc;
   logic [31:0] next_adr;

   assign id_valid  = (count_q != 2'd0);
   // A redirect flushes the queue, so a simultaneous pop must not count.
   assign pop       = id_valid && id_ready && !redirect;
   assign count_pop = count_q - {1'b0, pop};
   assign target_pc = {redirect_pc[31:2], 2'b00};
   assign next_adr  = adr_q + 32'd4;

   assign imem_adr  = adr_q;
   assign imem_req  = req_q;
   assign id_pc     = pc0_q;
   assign id_instr  = ins0_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      adr_d   = adr_q;
      req_d   = req_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               state_d = S_WAIT;
               req_d   = 1'b1;
               adr_d   = target_pc;
               pc_d    = target_pc;
            end else if (count_pop < 2'd2) begin
               state_d = S_WAIT;
               req_d   = 1'b1;
               adr_d   = pc_q;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d = target_pc;
               if (imem_done) begin
                  adr_d = target_pc;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (imem_done) begin
               push = 1'b1;
               pc_d = next_adr;
               // Room for one more word only if the queue is empty after this pop.
               if (count_pop == 2'd0) begin
                  adr_d = next_adr;
               end else begin
                  state_d = S_IDLE;
                  req_d   = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            if (redirect) pc_d = target_pc;
            if (imem_done) begin
               state_d = S_WAIT;
               adr_d   = redirect ? target_pc : pc_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      pc0_d   = pc0_q;
      ins0_d  = ins0_q;
      pc1_d   = pc1_q;
      ins1_d  = ins1_q;
      count_d = count_q;
      if (redirect) begin
         count_d = 2'd0;
      end else begin
         if (pop && count_q == 2'd2) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
         end
         if (push) begin
            if (count_pop == 2'd0) begin
               pc0_d  = adr_q;
               ins0_d = imem_rdata;
            end else begin
               pc1_d  = adr_q;
               ins1_d = imem_rdata;
            end
         end
         count_d = count_pop + {1'b0, push};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_ADR;
         adr_q   <= RESET_ADR;
         req_q   <= 1'b0;
         count_q <= 2'd0;
         pc0_q   <= 32'd0;
         ins0_q  <= 32'd0;
         pc1_q   <= 32'd0;
         ins1_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         adr_q   <= adr_d;
         req_q   <= req_d;
         count_q <= count_d;
         pc0_q   <= pc0_d;
         ins0_q  <= ins0_d;
         pc1_q   <= pc1_d;
         ins1_q  <= ins1_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, a memory responder and a scoreboard
// monitor that checks every word handed to decode against an expected queue.
module tb_fetch_unit;

   localparam logic [31:0] XK = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_adr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_done;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        id_ready = 1'b0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [1:0]  dbg_state;

   logic        mem_auto = 1'b0;
   int          mem_wait = 0;
   int          cyc = 0;
   logic        auto_done = 1'b0;
   logic [31:0] auto_rdata = 32'd0;
   logic        man_done = 1'b0;
   logic [31:0] man_rdata = 32'd0;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   int          n_edges;

   assign imem_done  = mem_auto ? auto_done : man_done;
   assign imem_rdata = mem_auto ? auto_rdata : man_rdata;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_adr   (imem_adr),
      .imem_req   (imem_req),
      .imem_rdata (imem_rdata),
      .imem_done  (imem_done),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .id_ready   (id_ready),
      .id_valid   (id_valid),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .dbg_state  (dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] word(input logic [31:0] a);
      return {a, a ^ XK};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model: returns addr^XK, done after mem_wait idle cycles of a request.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!mem_auto) begin
            cyc = 0;
            auto_done = 1'b0;
         end else begin
            if (auto_done) cyc = 0;
            if (imem_req) begin
               cyc++;
               auto_done  = (cyc > mem_wait);
               auto_rdata = imem_adr ^ XK;
            end else begin
               auto_done = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: every accepted word must match the head of exp_q.
   initial begin
      forever begin
         logic [63:0] e;
         @(negedge clk);
         if (rst_n && id_valid && id_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got pc %h instr %h expected none", id_pc, id_instr);
            end else begin
               e = exp_q.pop_front();
               chk("mon_pc", id_pc, e[63:32]);
               chk("mon_instr", id_instr, e[31:0]);
            end
         end
      end
   end

   task automatic do_reset();
      mem_auto    = 1'b0;
      man_done    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      id_ready    = 1'b0;
      rst_n       = 1'b0;
      #1;
      chk("rst_async_req", 32'(imem_req), 32'd0);
      chk("rst_async_valid", 32'(id_valid), 32'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_adr", imem_adr, 32'd0);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_instr", id_instr, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int bound, output int edges);
      edges = bound + 1;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) begin
            edges = i + 1;
            break;
         end
      end
      #1;
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and full-rate streaming
      do_reset();
      mem_auto = 1'b1;
      mem_wait = 0;
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(word(32'(4 * i)));
      release_rst();
      step();
      @(negedge clk);
      chk("s1_first_req", 32'(imem_req), 32'd1);
      chk("s1_first_adr", imem_adr, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("s1_valid", 32'(id_valid), 32'd1);
         chk("s1_adr", imem_adr, 32'(4 * (i + 1)));
      end
      step();
      id_ready = 1'b0;
      chk("s1_drained", 32'(exp_q.size()), 32'd0);

      // Slow memory: three cycles per word
      do_reset();
      mem_auto = 1'b1;
      mem_wait = 2;
      id_ready = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(word(32'(4 * i)));
      release_rst();
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("s2_adr_stable", imem_adr, 32'd0);
         chk("s2_req_held", 32'(imem_req), 32'd1);
      end
      wait_drain(40, n_edges);
      id_ready = 1'b0;
      chk("s2_spacing", 32'(n_edges), 32'd8);

      // Backpressure
      do_reset();
      mem_auto = 1'b1;
      mem_wait = 0;
      release_rst();
      repeat (6) step();
      @(negedge clk);
      chk("s3_req_off", 32'(imem_req), 32'd0);
      chk("s3_valid", 32'(id_valid), 32'd1);
      chk("s3_head_pc", id_pc, 32'd0);
      chk("s3_head_instr", id_instr, XK);
      chk("s3_state", 32'(dbg_state), 32'd0);
      exp_q.push_back(word(32'd0));
      step();
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
      @(negedge clk);
      chk("s3_head_after_pop", id_pc, 32'd4);
      chk("s3_instr_after_pop", id_instr, 32'd4 ^ XK);
      chk("s3_reissue_req", 32'(imem_req), 32'd1);
      chk("s3_reissue_adr", imem_adr, 32'd8);
      repeat (3) step();
      chk("s3_full_again", 32'(imem_req), 32'd0);
      chk("s3_head_held", id_pc, 32'd4);

      // Redirect while a request is outstanding
      do_reset();
      id_ready = 1'b1;
      release_rst();
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0010;
      man_done    = 1'b1;
      man_rdata   = 32'hBAD0_0000;
      step();
      redirect = 1'b0;
      man_done = 1'b0;
      @(negedge clk);
      chk("s4_adr_10", imem_adr, 32'h10);
      chk("s4_req", 32'(imem_req), 32'd1);
      chk("s4_valid0", 32'(id_valid), 32'd0);
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("s4_drain_state", 32'(dbg_state), 32'd2);
      chk("s4_drain_adr", imem_adr, 32'h10);
      chk("s4_drain_req", 32'(imem_req), 32'd1);
      step();
      man_done  = 1'b1;
      man_rdata = 32'hDEAD_0010;
      step();
      man_done = 1'b0;
      @(negedge clk);
      chk("s4_new_adr", imem_adr, 32'h100);
      chk("s4_new_state", 32'(dbg_state), 32'd1);
      chk("s4_no_stale", 32'(id_valid), 32'd0);
      exp_q.push_back(word(32'h100));
      step();
      man_done  = 1'b1;
      man_rdata = 32'h100 ^ XK;
      step();
      man_done = 1'b0;
      wait_drain(5, n_edges);
      id_ready = 1'b0;

      // Redirect, done and pop in one cycle with a full queue
      do_reset();
      release_rst();
      step();
      man_done  = 1'b1;
      man_rdata = XK;
      step();
      man_rdata = 32'd4 ^ XK;
      step();
      man_done = 1'b0;
      @(negedge clk);
      chk("s5_full_req", 32'(imem_req), 32'd0);
      chk("s5_full_valid", 32'(id_valid), 32'd1);
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      man_done    = 1'b1;
      man_rdata   = 32'hBAD0_0004;
      id_ready    = 1'b1;
      step();
      redirect = 1'b0;
      man_done = 1'b0;
      id_ready = 1'b0;
      @(negedge clk);
      chk("s5_flushed", 32'(id_valid), 32'd0);
      chk("s5_target_adr", imem_adr, 32'h200);
      chk("s5_target_req", 32'(imem_req), 32'd1);
      exp_q.push_back(word(32'h200));
      step();
      id_ready  = 1'b1;
      man_done  = 1'b1;
      man_rdata = 32'h200 ^ XK;
      step();
      man_done = 1'b0;
      wait_drain(5, n_edges);
      id_ready = 1'b0;

      // PC wrap-around
      do_reset();
      mem_auto = 1'b1;
      mem_wait = 0;
      release_rst();
      repeat (4) step();
      exp_q.push_back(word(32'hFFFF_FFF8));
      exp_q.push_back(word(32'hFFFF_FFFC));
      exp_q.push_back(word(32'h0000_0000));
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      id_ready    = 1'b1;
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("s6_adr", imem_adr, 32'hFFFF_FFF8);
      chk("s6_valid0", 32'(id_valid), 32'd0);
      wait_drain(20, n_edges);
      id_ready = 1'b0;

      // Reset asserted while a request is live
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
